// File: rtl/aes_encrypt_round_iter.sv
// Iterative AES forward cipher, one round per clock; out_valid NR edges after accept.
// Single block in flight: in_ready is low in ROUND and DONE, block_out held until out_ready.
module aes_encrypt_round_iter #(
    parameter int NR = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] block_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] block_out,
    output logic         busy
);

    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
        $error("aes_encrypt_round_iter: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR_L = 4'(NR);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t       st, st_nxt;
    logic [127:0] state_q;
    logic [3:0]   round_q;
    logic [127:0] block_out_q;
    logic         last_round;
    logic [127:0] round_out;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        int i;
        i = int'(x);
        return SBOX[2047 - 8*i -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of the block sits at row k%4, column k/4; byte 0 is the MSB.
    function automatic logic [127:0] round_f(input logic [127:0] s, input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int k = 0; k < 16; k++) begin
            sb[k] = sbox(s[127 - 8*k -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
            end
        end
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c + 1];
            a2 = sr[4*c + 2];
            a3 = sr[4*c + 3];
            if (last) begin
                o[127 - 32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127 - 32*c -: 32] = {
                    xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                    a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                    a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                    xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
                };
            end
        end
        return o;
    endfunction

    assign last_round = (round_q == NR_L);
    assign round_out  = round_f(state_q, last_round) ^ rk_in;
    assign block_out  = block_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt    = st;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rk_idx    = 4'd0;
        case (st)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_nxt = ROUND;
                end
            end
            ROUND: begin
                busy   = 1'b1;
                rk_idx = round_q;
                if (last_round) begin
                    st_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    st_nxt = IDLE;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    // block_out has its own register so it survives the next block's rounds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= '0;
            round_q     <= '0;
            block_out_q <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= block_in ^ rk_in;
                        round_q <= 4'd1;
                    end
                end
                ROUND: begin
                    state_q <= round_out;
                    if (last_round) begin
                        block_out_q <= round_out;
                        round_q     <= 4'd0;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_round_iter.sv
// Directed bench: FIPS-197 vectors on NR=14 and NR=10 instances, backpressure, back-to-back, reset abort.
module tb_aes_encrypt_round_iter;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] K128   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CTZERO = 128'hdc95c078a2408989ad48a21492842087;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] block_in, rk_in, block_out;
    logic [3:0]   rk_idx;
    logic         in_valid_10, in_ready_10, out_valid_10, out_ready_10, busy_10;
    logic [127:0] block_in_10, rk_in_10, block_out_10;
    logic [3:0]   rk_idx_10;

    logic [127:0] rks   [0:15];
    logic [127:0] rk10s [0:15];

    int n_cmp = 0;
    int n_err = 0;

    assign rk_in    = rks[rk_idx];
    assign rk_in_10 = rk10s[rk_idx_10];

    aes_encrypt_round_iter #(.NR(14)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .block_in(block_in),
        .rk_idx(rk_idx), .rk_in(rk_in),
        .out_valid(out_valid), .out_ready(out_ready), .block_out(block_out),
        .busy(busy)
    );

    aes_encrypt_round_iter #(.NR(10)) dut10 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_10), .in_ready(in_ready_10), .block_in(block_in_10),
        .rk_idx(rk_idx_10), .rk_in(rk_in_10),
        .out_valid(out_valid_10), .out_ready(out_ready_10), .block_out(block_out_10),
        .busy(busy_10)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] o;
        for (int k = 0; k < 4; k++) begin
            o[31 - 8*k -: 8] = SBOX[2047 - 8*int'(w[31 - 8*k -: 8]) -: 8];
        end
        return o;
    endfunction

    // Key store contents: the FIPS-197 key schedule, loaded into rks (nr=14) or rk10s (nr=10).
    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [0:63];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 64; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j < 16; j++) begin
            if (nr == 10) rk10s[j] = (j <= nr) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : '0;
            else          rks[j]   = (j <= nr) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : '0;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; checks the key index walk and the result.
    task automatic run14(input string tag, input logic [127:0] exp);
        for (int r = 1; r <= 14; r++) begin
            chk($sformatf("%s_rk_idx_r%0d", tag, r), 128'(rk_idx), 128'(r));
            chk($sformatf("%s_in_ready_r%0d", tag, r), 128'(in_ready), 128'(0));
            if (r == 14) chk({tag, "_out_valid_early"}, 128'(out_valid), 128'(0));
            tick();
        end
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(1));
        chk({tag, "_block_out"}, block_out, exp);
        chk({tag, "_rk_idx_done"}, 128'(rk_idx), 128'(0));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;     out_ready = 1'b0;     block_in = '0;
        in_valid_10 = 1'b0;  out_ready_10 = 1'b0;  block_in_10 = '0;
        expand(K256, 8, 14);
        expand({K128, 128'h0}, 4, 10);

        #3;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_rk_idx", 128'(rk_idx), 128'(0));
        chk("rst_block_out", block_out, 128'(0));
        chk("rst10_out_valid", 128'(out_valid_10), 128'(0));
        chk("rst10_block_out", block_out_10, 128'(0));
        #4 rst = 1'b0;
        tick();

        // FIPS-197 C.3 then backpressure
        block_in = PT;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        run14("c3", CT256);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("bp_out_valid_%0d", i), 128'(out_valid), 128'(1));
            chk($sformatf("bp_block_out_%0d", i), block_out, CT256);
            chk($sformatf("bp_in_ready_%0d", i), 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_out_valid", 128'(out_valid), 128'(0));
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        chk("bp_release_block_out", block_out, CT256);

        // Back-to-back with in_valid held high; second block uses the all-zero key
        block_in = PT;
        in_valid = 1'b1;
        tick();
        run14("b2b_first", CT256);
        expand('0, 8, 14);
        block_in = '0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("b2b_idle_in_ready", 128'(in_ready), 128'(1));
        chk("b2b_idle_out_valid", 128'(out_valid), 128'(0));
        tick();
        chk("b2b_second_accept_busy", 128'(busy), 128'(1));
        chk("b2b_block_out_held", block_out, CT256);
        in_valid = 1'b0;
        run14("zero", CTZERO);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset at round 7, then a clean C.3 run
        expand(K256, 8, 14);
        block_in = PT;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("abort_rk_idx_r7", 128'(rk_idx), 128'(7));
        #3 rst = 1'b1;
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        chk("abort_block_out", block_out, 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_rk_idx", 128'(rk_idx), 128'(0));
        in_valid = 1'b1;
        #2 rst = 1'b0;
        tick();
        chk("post_rst_accept_busy", 128'(busy), 128'(1));
        in_valid = 1'b0;
        run14("c3_after_rst", CT256);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // NR=10 instance, FIPS-197 C.1
        block_in_10 = PT;
        in_valid_10 = 1'b1;
        tick();
        in_valid_10 = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            chk($sformatf("c1_rk_idx_r%0d", r), 128'(rk_idx_10), 128'(r));
            chk($sformatf("c1_out_valid_r%0d", r), 128'(out_valid_10), 128'(0));
            tick();
        end
        chk("c1_out_valid", 128'(out_valid_10), 128'(1));
        chk("c1_block_out", block_out_10, CT128);
        out_ready_10 = 1'b1;
        tick();
        out_ready_10 = 1'b0;
        chk("c1_release_out_valid", 128'(out_valid_10), 128'(0));
        chk("c1_release_in_ready", 128'(in_ready_10), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
